// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply or restoring divide, one bit per cycle.
// Latency: done pulses XLEN+2 cycles after an accepted start (2 cycles for divide special cases).
// Backpressure: none; start is taken only in IDLE, and busy tells the core to stall.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start, op, a, b   request and operands, captured when start is seen in IDLE
//   busy              high from the cycle after acceptance through the done cycle
//   done, result      one-cycle completion pulse; result holds until the next done
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic              neg_q;      // final result must be negated
    logic              special_q;  // result already sits in acc low half
    logic [XLEN-1:0]   opnd_q;     // multiplicand magnitude or divisor magnitude
    // Multiply: {product_hi, multiplier/product_lo}. Divide: {remainder, dividend/quotient}.
    logic [2*XLEN-1:0] acc;

    // ---------------- start-time decode ----------------
    logic            a_sgn, b_sgn;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div0, ovf, special;
    logic [XLEN-1:0] special_res;
    logic            neg_in;

    always_comb begin
        a_sgn       = 1'b0;
        b_sgn       = 1'b0;
        a_mag       = a;
        b_mag       = b;
        div0        = 1'b0;
        ovf         = 1'b0;
        special     = 1'b0;
        special_res = '0;
        neg_in      = 1'b0;

        if (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM)
            a_sgn = a[XLEN-1];
        if (op == OP_MULH || op == OP_DIV || op == OP_REM)
            b_sgn = b[XLEN-1];
        if (a_sgn) a_mag = -a;
        if (b_sgn) b_mag = -b;

        div0    = op[2] && (b == '0);
        ovf     = (op == OP_DIV || op == OP_REM) && (a == MIN_NEG) && (b == '1);
        special = div0 || ovf;

        if (div0)
            special_res = (op == OP_DIV || op == OP_DIVU) ? '1 : a;
        else if (ovf)
            special_res = (op == OP_DIV) ? MIN_NEG : '0;

        // Remainder follows the dividend's sign; everything else the product/quotient sign.
        neg_in = (op == OP_REM) ? a_sgn : (a_sgn ^ b_sgn);
    end

    // ---------------- per-iteration datapath ----------------
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_tmp;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] mul_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   res_sel;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd_q : {XLEN{1'b0}})};
        div_tmp  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff = div_tmp - {1'b0, opnd_q};

        mul_fix  = neg_q ? -acc : acc;
        quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

        res_sel = acc[XLEN-1:0];
        if (!special_q) begin
            case (op_q)
                OP_MUL:                      res_sel = acc[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU: res_sel = mul_fix[2*XLEN-1:XLEN];
                OP_DIV, OP_DIVU:             res_sel = quo_fix;
                default:                     res_sel = rem_fix;
            endcase
        end
    end

    // ---------------- control + state ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            op_q      <= OP_MUL;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            opnd_q    <= '0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy      <= 1'b1;
                        cnt       <= '0;
                        op_q      <= op;
                        neg_q     <= neg_in;
                        special_q <= special;
                        if (special) begin
                            acc   <= {{XLEN{1'b0}}, special_res};
                            state <= SIGN;
                        end else begin
                            opnd_q <= op[2] ? b_mag : a_mag;
                            acc    <= {{XLEN{1'b0}}, (op[2] ? a_mag : b_mag)};
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_q[2]) begin
                        // Restoring step: keep the trial difference only if it did not borrow.
                        if (!div_diff[XLEN])
                            acc <= {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                        else
                            acc <= {acc[2*XLEN-2:0], 1'b0};
                    end else begin
                        acc <= {mul_sum, acc[XLEN-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(XLEN-1))
                        state <= SIGN;
                end
                SIGN: begin
                    result <= res_sel;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
